// File: rtl/filter_out_fifo.sv
// filter_out_fifo: output stage behind the serial shift-add FIR.
// Takes each strobed FIR result, keeps one of every (i_decim+1) samples, and
// buffers the kept ones in a first-word-fall-through FIFO with a valid/ready
// output. A sample that arrives while the FIFO is full and not being read is
// dropped, and o_ovf_cnt counts it.
// Optional build macro FILTER_OUT_SAT_DETECT_EN adds the o_sat_cnt port. It
// counts kept samples that carry one of the FIR saturation codes.
module filter_out_fifo #(
    parameter int DW    = 18,
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int CNTW  = 8
) (
    input  logic            i_clk,
    input  logic            i_arst_n,
    input  logic            i_sample_stb,
    input  logic [DW-1:0]   i_filter,
    input  logic [3:0]      i_decim,
    output logic [DW-1:0]   o_data,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [AW:0]     o_level,
    output logic [CNTW-1:0] o_ovf_cnt,
    input  logic            i_clr_cnt
`ifdef FILTER_OUT_SAT_DETECT_EN
    ,
    output logic [CNTW-1:0] o_sat_cnt
`endif
);

    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     level;
    logic [3:0]      dcnt;
    logic [CNTW-1:0] ovf_cnt;
    logic            accept;
    logic            full;
    logic            rd_en;
    logic            wr_en;
    logic            drop;

    assign o_valid   = (level != '0);
    assign o_data    = o_valid ? mem[rd_ptr] : '0;
    assign o_level   = level;
    assign o_ovf_cnt = ovf_cnt;

    // Write/read/drop qualification; a full FIFO still takes a sample when the head leaves in the same cycle
    always_comb begin
        accept = i_sample_stb && (dcnt == 4'd0);
        full   = (level == (AW+1)'(DEPTH));
        rd_en  = o_valid && i_ready;
        wr_en  = accept && (!full || rd_en);
        drop   = accept && full && !rd_en;
    end

    // Decimation phase: >= compare lets a lowered i_decim wrap on the next strobe
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n)
            dcnt <= '0;
        else if (i_sample_stb)
            dcnt <= (dcnt >= i_decim) ? 4'd0 : dcnt + 4'd1;
    end

    // Pointers and a registered occupancy counter; a simultaneous write and read leave level unchanged
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sample storage; contents need no reset because o_data is masked while empty
    always_ff @(posedge i_clk) begin
        if (wr_en)
            mem[wr_ptr] <= i_filter;
    end

    // Dropped-sample counter, saturating; clear wins over a same-cycle drop
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n)
            ovf_cnt <= '0;
        else if (i_clr_cnt)
            ovf_cnt <= '0;
        else if (drop && (ovf_cnt != '1))
            ovf_cnt <= ovf_cnt + 1'b1;
    end

`ifdef FILTER_OUT_SAT_DETECT_EN
    localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    logic [CNTW-1:0] sat_cnt;
    logic            is_sat;

    assign is_sat    = accept && ((i_filter == SAT_MAX) || (i_filter == SAT_MIN));
    assign o_sat_cnt = sat_cnt;

    // Saturation-code counter over kept samples, including ones dropped on overflow
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n)
            sat_cnt <= '0;
        else if (i_clr_cnt)
            sat_cnt <= '0;
        else if (is_sat && (sat_cnt != '1))
            sat_cnt <= sat_cnt + 1'b1;
    end
`endif

endmodule
